mem_access_stage: RTL and testbench

- Memory-access pipeline stage that sits between EX and WB; it is the transmitter side of the ms_to_ws valid/allowin handshake and the 232-bit ms_to_ws_bus.
- Accepts one instruction per handshake from EX and performs at most one data-memory access per instruction over a simple req/ack/resp port.
- Extracts and extends load data, then presents the WB bus.
- Holds the instruction until WB accepts it.

---
 rtl/mem_access_stage_pkg.sv | 49 ++++
 rtl/mem_access_stage_load_store_align.sv | 47 ++++
 rtl/mem_access_stage.sv | 123 ++++++++++++
 tb/tb_mem_access_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared encodings and bus layouts for the memory-access stage.
// The packed structs fix the field order and widths of both pipeline buses.
package mem_access_stage_pkg;

    localparam logic [1:0] WREG_PC  = 2'd0;
    localparam logic [1:0] WREG_ALU = 2'd1;
    localparam logic [1:0] WREG_RAM = 2'd2;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } ms_state_e;

    // es_to_ms_bus, MSB first (237 bits)
    typedef struct packed {
        logic [31:0] inst;
        logic        reg_wen;
        logic [4:0]  rd;
        logic [1:0]  wreg_sel;
        logic        mem_re;
        logic        mem_we;
        mem_size_e   mem_size;
        logic        mem_unsigned;
        logic [63:0] store_data;
        logic [63:0] alu_result;
        logic [63:0] pc;
    } es_bus_t;

    // ms_to_ws_bus, MSB first (232 bits)
    typedef struct packed {
        logic [31:0] inst;
        logic        reg_wen;
        logic [4:0]  rd;
        logic [1:0]  wreg_sel;
        logic [63:0] rdata;
        logic [63:0] alu_result;
        logic [63:0] pc;
    } ms_bus_t;

endpackage

// File: rtl/mem_access_stage_load_store_align.sv
// Byte-lane steering for stores and extraction/extension of load data.
// Purely combinational so it can be exercised on its own.
module load_store_align
    import mem_access_stage_pkg::*;
(
    input  logic [2:0]  off,
    input  mem_size_e   size,
    input  logic        is_unsigned,
    input  logic [63:0] store_data,
    input  logic [63:0] rdata,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic [63:0] load_data
);

    logic [63:0] lane;

    always_comb begin
        lane      = rdata >> {off, 3'b000};
        wdata     = store_data;
        wstrb     = 8'hFF;
        load_data = lane;
        case (size)
            SIZE_B: begin
                wdata     = {8{store_data[7:0]}};
                wstrb     = 8'h01 << off;
                load_data = is_unsigned ? {56'd0, lane[7:0]} : {{56{lane[7]}}, lane[7:0]};
            end
            SIZE_H: begin
                wdata     = {4{store_data[15:0]}};
                wstrb     = 8'h03 << {off[2:1], 1'b0};
                load_data = is_unsigned ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            end
            SIZE_W: begin
                wdata     = {2{store_data[31:0]}};
                wstrb     = 8'h0F << {off[2], 2'b00};
                load_data = is_unsigned ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            end
            SIZE_D: begin
                wdata     = store_data;
                wstrb     = 8'hFF;
                load_data = lane;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: latches from EX, performs at most one data access per
// instruction over req/ack/resp, and holds the result until WB accepts it.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int ES_BUS_W = 237,
    parameter int MS_BUS_W = 232
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                es_to_ms_valid,
    input  logic [ES_BUS_W-1:0] es_to_ms_bus,
    output logic                ms_allowin,
    input  logic                ws_allowin,
    output logic                ms_to_ws_valid,
    output logic [MS_BUS_W-1:0] ms_to_ws_bus,
    output logic                data_req,
    output logic                data_wr,
    output logic [XLEN-1:0]     data_addr,
    output logic [XLEN-1:0]     data_wdata,
    output logic [7:0]          data_wstrb,
    output logic [1:0]          data_size,
    input  logic                data_addr_ok,
    input  logic                data_resp_valid,
    input  logic [XLEN-1:0]     data_rdata
);

    es_bus_t     es_in;
    es_bus_t     bus_reg;
    ms_bus_t     ms_out;
    ms_state_e   state_reg;
    logic        ms_valid_reg;
    logic        data_req_reg;
    logic [63:0] rdata_reg;

    logic        ms_is_mem;
    logic        ms_ready_go;
    logic [63:0] align_wdata;
    logic [7:0]  align_wstrb;
    logic [63:0] align_load;

    assign es_in       = es_to_ms_bus;
    assign ms_is_mem   = bus_reg.mem_re | bus_reg.mem_we;
    assign ms_ready_go = !ms_is_mem || (state_reg == S_DONE);
    assign ms_allowin  = !ms_valid_reg || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_reg && ms_ready_go;

    load_store_align u_align (
        .off         (bus_reg.alu_result[2:0]),
        .size        (bus_reg.mem_size),
        .is_unsigned (bus_reg.mem_unsigned),
        .store_data  (bus_reg.store_data),
        .rdata       (data_rdata),
        .wdata       (align_wdata),
        .wstrb       (align_wstrb),
        .load_data   (align_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_valid_reg <= 1'b0;
            bus_reg      <= '0;
            rdata_reg    <= '0;
            data_req_reg <= 1'b0;
            state_reg    <= S_IDLE;
        end else begin
            if (ms_allowin) begin
                ms_valid_reg <= es_to_ms_valid;
            end
            // A fresh instruction starts with a cleared rdata so non-loads present 0.
            if (es_to_ms_valid && ms_allowin) begin
                bus_reg   <= es_in;
                rdata_reg <= '0;
            end
            case (state_reg)
                S_IDLE: begin
                    if (ms_valid_reg && ms_is_mem) begin
                        state_reg    <= S_REQ;
                        data_req_reg <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (data_addr_ok) begin
                        state_reg    <= S_WAIT;
                        data_req_reg <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (data_resp_valid) begin
                        rdata_reg <= bus_reg.mem_re ? align_load : 64'd0;
                        state_reg <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (ws_allowin) begin
                        state_reg <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        ms_out            = '0;
        ms_out.inst       = bus_reg.inst;
        ms_out.reg_wen    = bus_reg.reg_wen;
        ms_out.rd         = bus_reg.rd;
        ms_out.wreg_sel   = bus_reg.wreg_sel;
        ms_out.rdata      = rdata_reg;
        ms_out.alu_result = bus_reg.alu_result;
        ms_out.pc         = bus_reg.pc;
    end

    assign ms_to_ws_bus = ms_out;
    assign data_req     = data_req_reg;
    assign data_wr      = bus_reg.mem_we;
    assign data_addr    = {bus_reg.alu_result[63:3], 3'b000};
    assign data_wdata   = align_wdata;
    assign data_wstrb   = bus_reg.mem_we ? align_wstrb : 8'h00;
    assign data_size    = bus_reg.mem_size;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed instructions, a scripted
// memory agent, and a WB-side monitor that checks each retired instruction.
module tb_mem_access_stage;

    logic         clk;
    logic         rst_n;
    logic         es_to_ms_valid;
    logic [236:0] es_to_ms_bus;
    logic         ms_allowin;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [231:0] ms_to_ws_bus;
    logic         data_req;
    logic         data_wr;
    logic [63:0]  data_addr;
    logic [63:0]  data_wdata;
    logic [7:0]   data_wstrb;
    logic [1:0]   data_size;
    logic         data_addr_ok;
    logic         data_resp_valid;
    logic [63:0]  data_rdata;

    typedef struct {
        logic [63:0] addr;
        logic        wr;
        logic [7:0]  wstrb;
        logic [63:0] wdata;
        logic [1:0]  size;
        logic [63:0] rdata;
        int          ok_dly;
        int          resp_dly;
    } mem_t;

    logic [231:0] sb[$];
    mem_t         mq[$];
    int           checks = 0;
    int           errors = 0;
    logic         in_wait = 1'b0;

    mem_access_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_allowin      (ms_allowin),
        .ws_allowin      (ws_allowin),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_wstrb      (data_wstrb),
        .data_size       (data_size),
        .data_addr_ok    (data_addr_ok),
        .data_resp_valid (data_resp_valid),
        .data_rdata      (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [236:0] mk_es(input logic [31:0] inst, input logic wen, input logic [4:0] rd,
                                           input logic [1:0] wsel, input logic re, input logic we,
                                           input logic [1:0] size, input logic uns, input logic [63:0] sdata,
                                           input logic [63:0] alu, input logic [63:0] pc);
        return {inst, wen, rd, wsel, re, we, size, uns, sdata, alu, pc};
    endfunction

    function automatic logic [231:0] mk_ms(input logic [31:0] inst, input logic wen, input logic [4:0] rd,
                                           input logic [1:0] wsel, input logic [63:0] rdata,
                                           input logic [63:0] alu, input logic [63:0] pc);
        return {inst, wen, rd, wsel, rdata, alu, pc};
    endfunction

    task automatic push_mem(input logic [63:0] addr, input logic wr, input logic [7:0] strb,
                            input logic [63:0] wdata, input logic [1:0] size, input logic [63:0] rdata,
                            input int ok_dly, input int resp_dly);
        mem_t m;
        m.addr = addr; m.wr = wr; m.wstrb = strb; m.wdata = wdata;
        m.size = size; m.rdata = rdata; m.ok_dly = ok_dly; m.resp_dly = resp_dly;
        mq.push_back(m);
    endtask

    // Present one instruction to the stage and return #1 after the edge that latches it.
    task automatic send(input logic [236:0] b, input logic [231:0] e);
        int n;
        es_to_ms_bus   = b;
        es_to_ms_valid = 1'b1;
        sb.push_back(e);
        n = 0;
        @(negedge clk);
        while (!ms_allowin && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ms_allowin) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ms_allowin stayed 0 for %0d cycles", n);
        end
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
    endtask

    // Memory agent: answers each request with the scripted delays.
    initial begin
        mem_t m;
        logic abort;
        data_addr_ok    = 1'b0;
        data_resp_valid = 1'b0;
        data_rdata      = '0;
        forever begin
            @(negedge clk);
            if (rst_n && data_req) begin
                if (mq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_req: got data_req=1 addr=%h required no request", data_addr);
                end else begin
                    m = mq.pop_front();
                    chk("req_addr", data_addr, m.addr);
                    chk("req_wr", data_wr, m.wr);
                    chk("req_wstrb", data_wstrb, m.wstrb);
                    chk("req_wdata", data_wdata, m.wdata);
                    chk("req_size", data_size, m.size);
                    abort = 1'b0;
                    for (int i = 0; i < m.ok_dly; i++) @(negedge clk);
                    data_addr_ok = 1'b1;
                    @(negedge clk);
                    data_addr_ok = 1'b0;
                    in_wait = 1'b1;
                    for (int i = 1; i < m.resp_dly; i++) begin
                        @(negedge clk);
                        if (!rst_n) begin
                            abort = 1'b1;
                            break;
                        end
                    end
                    if (!abort) begin
                        data_resp_valid = 1'b1;
                        data_rdata      = m.rdata;
                        @(negedge clk);
                        data_resp_valid = 1'b0;
                        data_rdata      = '0;
                    end
                    in_wait = 1'b0;
                end
            end
        end
    end

    // WB-side monitor: every accepted instruction is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && ms_to_ws_valid && ws_allowin) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got bus=%h required nothing", ms_to_ws_bus);
            end else begin
                chk("ws_bus", ms_to_ws_bus, sb.pop_front());
            end
            $display("ws xfer pc=%h inst=%h rdata=%h", ms_to_ws_bus[63:0], ms_to_ws_bus[231:200],
                     ms_to_ws_bus[191:128]);
        end
    end

    initial begin
        logic [231:0] exp_l1;
        int n;
        rst_n          = 1'b0;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus   = '0;
        ws_allowin     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", ms_to_ws_valid, 1'b0);
        chk("rst_req", data_req, 1'b0);
        chk("rst_allowin", ms_allowin, 1'b1);
        chk("rst_bus", ms_to_ws_bus, 232'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU op: valid to WB the cycle after latch, no memory request
        send(mk_es(32'h00A00093, 1, 5'd1, 2'd1, 0, 0, 2'd0, 0, 64'd0, 64'd10, 64'h80000000),
             mk_ms(32'h00A00093, 1, 5'd1, 2'd1, 64'd0, 64'd10, 64'h80000000));
        chk("alu_latency", ms_to_ws_valid, 1'b1);

        // lb at offset 3, slow handshake
        push_mem(64'h80001000, 0, 8'h00, 64'd0, 2'd0, 64'h0000_0000_8000_0000, 2, 3);
        send(mk_es(32'h00308083, 1, 5'd1, 2'd2, 1, 0, 2'd0, 0, 64'd0, 64'h80001003, 64'h80000004),
             mk_ms(32'h00308083, 1, 5'd1, 2'd2, 64'hFFFF_FFFF_FFFF_FF80, 64'h80001003, 64'h80000004));
        chk("lb_not_early", ms_to_ws_valid, 1'b0);

        // lhu at offset 6
        push_mem(64'h80001000, 0, 8'h00, 64'd0, 2'd1, 64'hBEEF_0000_0000_0000, 0, 1);
        send(mk_es(32'h0060D103, 1, 5'd2, 2'd2, 1, 0, 2'd1, 1, 64'd0, 64'h80001006, 64'h80000008),
             mk_ms(32'h0060D103, 1, 5'd2, 2'd2, 64'h0000_0000_0000_BEEF, 64'h80001006, 64'h80000008));

        // sw at offset 4; ack data must not leak into rdata
        push_mem(64'h80001000, 1, 8'hF0, 64'h11223344_11223344, 2'd2, 64'hDEADBEEF_DEADBEEF, 1, 2);
        send(mk_es(32'h0020A223, 0, 5'd0, 2'd1, 0, 1, 2'd2, 0, 64'h11223344, 64'h80001004, 64'h8000000C),
             mk_ms(32'h0020A223, 0, 5'd0, 2'd1, 64'd0, 64'h80001004, 64'h8000000C));

        // sb at offset 5, upper store bits ignored
        push_mem(64'h80001000, 1, 8'h20, 64'hABABABAB_ABABABAB, 2'd0, 64'd0, 0, 1);
        send(mk_es(32'h002082A3, 0, 5'd0, 2'd1, 0, 1, 2'd0, 0, 64'h12345678_9ABCDEAB, 64'h80001005, 64'h80000010),
             mk_ms(32'h002082A3, 0, 5'd0, 2'd1, 64'd0, 64'h80001005, 64'h80000010));

        // sh at offset 2
        push_mem(64'h80001000, 1, 8'h0C, 64'hBEEFBEEF_BEEFBEEF, 2'd1, 64'd0, 0, 1);
        send(mk_es(32'h00209123, 0, 5'd0, 2'd1, 0, 1, 2'd1, 0, 64'hFFFF0000_0000BEEF, 64'h80001002, 64'h80000014),
             mk_ms(32'h00209123, 0, 5'd0, 2'd1, 64'd0, 64'h80001002, 64'h80000014));

        // lw signed at offset 4
        push_mem(64'h80001000, 0, 8'h00, 64'd0, 2'd2, 64'h87654321_00000000, 0, 1);
        send(mk_es(32'h0040A183, 1, 5'd3, 2'd2, 1, 0, 2'd2, 0, 64'd0, 64'h80001004, 64'h80000018),
             mk_ms(32'h0040A183, 1, 5'd3, 2'd2, 64'hFFFFFFFF_87654321, 64'h80001004, 64'h80000018));

        // ld
        push_mem(64'h80001008, 0, 8'h00, 64'd0, 2'd3, 64'h01234567_89ABCDEF, 1, 1);
        send(mk_es(32'h0080B203, 1, 5'd4, 2'd2, 1, 0, 2'd3, 0, 64'd0, 64'h80001008, 64'h8000001C),
             mk_ms(32'h0080B203, 1, 5'd4, 2'd2, 64'h01234567_89ABCDEF, 64'h80001008, 64'h8000001C));

        // WB stall with a load in DONE
        exp_l1 = mk_ms(32'h00013283, 1, 5'd5, 2'd2, 64'h11112222_33334444, 64'h80002000, 64'h80000020);
        push_mem(64'h80002000, 0, 8'h00, 64'd0, 2'd3, 64'h11112222_33334444, 1, 2);
        send(mk_es(32'h00013283, 1, 5'd5, 2'd2, 1, 0, 2'd3, 0, 64'd0, 64'h80002000, 64'h80000020), exp_l1);
        ws_allowin = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ms_to_ws_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach_done", ms_to_ws_valid, 1'b1);
        push_mem(64'h80002000, 0, 8'h00, 64'd0, 2'd2, 64'h80000000_00000000, 0, 1);
        sb.push_back(mk_ms(32'h00416303, 1, 5'd6, 2'd2, 64'h00000000_80000000, 64'h80002004, 64'h80000024));
        es_to_ms_bus   = mk_es(32'h00416303, 1, 5'd6, 2'd2, 1, 0, 2'd2, 1, 64'd0, 64'h80002004, 64'h80000024);
        es_to_ms_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("stall_bus", ms_to_ws_bus, exp_l1);
            chk("stall_valid", ms_to_ws_valid, 1'b1);
            chk("stall_allowin", ms_allowin, 1'b0);
            chk("stall_no_req", data_req, 1'b0);
        end
        @(posedge clk);
        #1;
        ws_allowin = 1'b1;
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
        chk("release_req_low", data_req, 1'b0);
        @(posedge clk);
        #1;
        chk("release_req_next", data_req, 1'b1);

        // Reset while the load waits for its response
        push_mem(64'h80003000, 0, 8'h00, 64'd0, 2'd0, 64'h0, 0, 30);
        send(mk_es(32'h00114383, 1, 5'd7, 2'd2, 1, 0, 2'd0, 1, 64'd0, 64'h80003001, 64'h80000028),
             mk_ms(32'h00114383, 1, 5'd7, 2'd2, 64'd0, 64'h80003001, 64'h80000028));
        n = 0;
        while (!in_wait && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_wait", in_wait, 1'b1);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        chk("midrst_valid", ms_to_ws_valid, 1'b0);
        chk("midrst_req", data_req, 1'b0);
        chk("midrst_bus", ms_to_ws_bus, 232'd0);
        chk("midrst_addr", data_addr, 64'd0);
        chk("midrst_wstrb", data_wstrb, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(mk_es(32'h002081B3, 1, 5'd3, 2'd1, 0, 0, 2'd0, 0, 64'd0, 64'h30, 64'h80000100),
             mk_ms(32'h002081B3, 1, 5'd3, 2'd1, 64'd0, 64'h30, 64'h80000100));
        chk("post_rst_latency", ms_to_ws_valid, 1'b1);
        push_mem(64'h80001000, 0, 8'h00, 64'd0, 2'd0, 64'h00000000_007F0000, 0, 1);
        send(mk_es(32'h00208083, 1, 5'd1, 2'd2, 1, 0, 2'd0, 0, 64'd0, 64'h80001002, 64'h80000104),
             mk_ms(32'h00208083, 1, 5'd1, 2'd2, 64'h7F, 64'h80001002, 64'h80000104));

        n = 0;
        while ((sb.size() != 0 || mq.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("sb_drain", sb.size(), 0);
        chk("mq_drain", mq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
